// File: rtl/sys_defs.sv
// Shared retire-path definitions: ROB exit packet, retire FSM states and sizing.
// Width macros N and PHYS_REG_SZ may be overridden on the command line.
`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

package sys_defs;
   localparam int RETIRE_N    = `N;
   localparam int ARCH_REG_SZ = 32;
   localparam int PHYS_REG_SZ = `PHYS_REG_SZ;
   localparam int ARCH_TAG_W  = $clog2(ARCH_REG_SZ);
   localparam int PHYS_TAG_W  = $clog2(PHYS_REG_SZ);

   typedef struct packed {
      logic                  complete;
      logic                  has_dest;
      logic [ARCH_TAG_W-1:0] arch_dest;
      logic [PHYS_TAG_W-1:0] t_new;
      logic [PHYS_TAG_W-1:0] t_old;
      logic                  halt;
      logic                  mispredict;
   } ROB_EXIT_PACKET;

   typedef enum logic [1:0] {RUN, FLUSH, HALTED} retire_state_e;

   typedef enum logic [1:0] {STOP_NONE, STOP_HALT, STOP_MISPRED} stop_reason_e;
endpackage

// File: rtl/retire_select.sv
// In-order retire selection: walks the valid ROB head entries oldest-first and
// stops at the first incomplete entry or just after a halt/mispredict.
module retire_select
   import sys_defs::*;
#(
   parameter  int N               = RETIRE_N,
   localparam int NUM_SCALAR_BITS = $clog2(N + 1)
)(
   input  ROB_EXIT_PACKET [N-1:0]         rob_outputs,
   input  logic [NUM_SCALAR_BITS-1:0]     outputs_valid,
   output logic [NUM_SCALAR_BITS-1:0]     num_retiring,
   output logic [N-1:0]                   retire_mask,
   output stop_reason_e                   stop_reason
);

   logic [N-1:0] w_in_range;
   logic         w_done;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_range
         assign w_in_range[gi] = (outputs_valid > NUM_SCALAR_BITS'(gi));
      end
   endgenerate

   // Halt is tested before mispredict so an entry carrying both reports halt.
   always_comb begin
      num_retiring = '0;
      retire_mask  = '0;
      stop_reason  = STOP_NONE;
      w_done       = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!w_done) begin
            if (!w_in_range[i] || !rob_outputs[i].complete) begin
               w_done = 1'b1;
            end else begin
               retire_mask[i] = 1'b1;
               num_retiring   = num_retiring + NUM_SCALAR_BITS'(1);
               if (rob_outputs[i].halt) begin
                  stop_reason = STOP_HALT;
                  w_done      = 1'b1;
               end else if (rob_outputs[i].mispredict) begin
                  stop_reason = STOP_MISPRED;
                  w_done      = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/retire_stage.sv
// Retire stage: in-order commit into the architectural map, t_old release and
// halt/flush sequencing. Optional statistics counters under RETIRE_STATS_EN.
module retire_stage
   import sys_defs::*;
#(
   parameter  int N               = RETIRE_N,
   parameter  int ARCH_REGS       = ARCH_REG_SZ,
   parameter  int PHYS_REGS       = PHYS_REG_SZ,
   localparam int NUM_SCALAR_BITS = $clog2(N + 1),
   localparam int PHYS_BITS       = $clog2(PHYS_REGS)
)(
   input  logic                                clock,
   input  logic                                reset,
   input  ROB_EXIT_PACKET [N-1:0]              rob_outputs,
   input  logic [NUM_SCALAR_BITS-1:0]          outputs_valid,
   output logic [NUM_SCALAR_BITS-1:0]          num_retiring,
   output logic [N-1:0]                        free_valid,
   output logic [N-1:0][PHYS_BITS-1:0]         free_tags,
   output logic [ARCH_REGS-1:0][PHYS_BITS-1:0] arch_map,
   output logic                                rollback,
   output logic                                halted
`ifdef RETIRE_STATS_EN
   ,
   output logic [63:0]                         retired_count,
   output logic [63:0]                         cycle_count
`endif
);

   retire_state_e                       r_state;
   retire_state_e                       w_state_next;
   logic [NUM_SCALAR_BITS-1:0]          w_sel_count;
   logic [N-1:0]                        w_sel_mask;
   stop_reason_e                        w_stop;
   logic                                w_run;
   logic [N-1:0]                        w_commit;
   logic [ARCH_REGS-1:0][PHYS_BITS-1:0] r_arch_map;

   retire_select #(.N(N)) u_select (
      .rob_outputs   (rob_outputs),
      .outputs_valid (outputs_valid),
      .num_retiring  (w_sel_count),
      .retire_mask   (w_sel_mask),
      .stop_reason   (w_stop)
   );

   assign w_run        = (r_state == RUN);
   assign num_retiring = w_run ? w_sel_count : '0;

   // Writes to arch register 0 are architecturally discarded, so they neither
   // commit nor release their t_old.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_free
         assign w_commit[gi]   = w_run && w_sel_mask[gi] && rob_outputs[gi].has_dest
                                 && (rob_outputs[gi].arch_dest != '0);
         assign free_valid[gi] = w_commit[gi];
         assign free_tags[gi]  = w_commit[gi] ? PHYS_BITS'(rob_outputs[gi].t_old) : '0;
      end
   endgenerate

   // Ascending loop order makes the youngest writer of a shared arch_dest win.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            r_arch_map[i] <= PHYS_BITS'(i);
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_commit[i]) begin
               r_arch_map[rob_outputs[i].arch_dest] <= PHYS_BITS'(rob_outputs[i].t_new);
            end
         end
      end
   end

   assign arch_map = r_arch_map;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN: begin
            if (w_stop == STOP_HALT) begin
               w_state_next = HALTED;
            end else if (w_stop == STOP_MISPRED) begin
               w_state_next = FLUSH;
            end
         end
         FLUSH:   w_state_next = RUN;
         HALTED:  w_state_next = HALTED;
         default: w_state_next = RUN;
      endcase
   end

   assign rollback = (r_state == FLUSH);
   assign halted   = (r_state == HALTED);

`ifdef RETIRE_STATS_EN
   logic [63:0] r_retired_count;
   logic [63:0] r_cycle_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_retired_count <= '0;
         r_cycle_count   <= '0;
      end else begin
         r_retired_count <= r_retired_count + 64'(num_retiring);
         if (!halted) begin
            r_cycle_count <= r_cycle_count + 64'd1;
         end
      end
   end

   assign retired_count = r_retired_count;
   assign cycle_count   = r_cycle_count;

   always @(posedge clock) begin
      if (!reset && w_run && (w_stop == STOP_HALT)) begin
         $display("retire_stage halt: retired=%0d cycles=%0d",
                  r_retired_count + 64'(num_retiring), r_cycle_count + 64'd1);
      end
   end
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: directed scenarios plus randomized ROB head traffic
// checked every cycle against an in-bench behavioural model.
module tb_retire_stage;
   import sys_defs::*;

   localparam int N   = RETIRE_N;
   localparam int NSB = $clog2(N + 1);
   localparam int PB  = PHYS_TAG_W;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   ROB_EXIT_PACKET [N-1:0]        rob;
   logic [NSB-1:0]                ov;
   logic [NSB-1:0]                num_retiring;
   logic [N-1:0]                  free_valid;
   logic [N-1:0][PB-1:0]          free_tags;
   logic [ARCH_REG_SZ-1:0][PB-1:0] arch_map;
   logic                          rollback;
   logic                          halted;
`ifdef RETIRE_STATS_EN
   logic [63:0]                   retired_count;
   logic [63:0]                   cycle_count;
`endif

   retire_stage dut (
      .clock         (clk),
      .reset         (rst),
      .rob_outputs   (rob),
      .outputs_valid (ov),
      .num_retiring  (num_retiring),
      .free_valid    (free_valid),
      .free_tags     (free_tags),
      .arch_map      (arch_map),
      .rollback      (rollback),
      .halted        (halted)
`ifdef RETIRE_STATS_EN
      ,
      .retired_count (retired_count),
      .cycle_count   (cycle_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model state: architectural map plus "halted" and "flush pending" flags.
   logic [PB-1:0] m_map [ARCH_REG_SZ];
   bit            m_halt;
   bit            m_flush;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic ROB_EXIT_PACKET mk(input bit c, input bit hd, input int d,
                                         input int tn, input int to, input bit h, input bit mp);
      ROB_EXIT_PACKET p;
      p.complete   = c;
      p.has_dest   = hd;
      p.arch_dest  = ARCH_TAG_W'(d);
      p.t_new      = PB'(tn);
      p.t_old      = PB'(to);
      p.halt       = h;
      p.mispredict = mp;
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ARCH_REG_SZ; i++) m_map[i] = PB'(i);
      m_halt  = 1'b0;
      m_flush = 1'b0;
   endtask

   task automatic rand_inputs(input bit allow_halt);
      for (int i = 0; i < N; i++) begin
         rob[i] = mk($urandom_range(0, 99) < 85,
                     $urandom_range(0, 3) != 0,
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
                     int'($urandom_range(0, PHYS_REG_SZ - 1)),
                     int'($urandom_range(0, PHYS_REG_SZ - 1)),
                     allow_halt && ($urandom_range(0, 99) < 3),
                     $urandom_range(0, 99) < 8);
      end
      ov = NSB'($urandom_range(0, N));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare process: inputs are stable from posedge+1 to the next posedge,
   // so the model predicts this cycle's outputs and then advances itself.
   always @(negedge clk) begin
      if (rst) begin
         model_reset();
      end else if (chk_en) begin
         int            n;
         int            why;
         logic [N-1:0]  efv;
         n   = 0;
         why = 0;
         efv = '0;
         if (!m_halt && !m_flush) begin
            for (int i = 0; i < int'(ov); i++) begin
               if (!rob[i].complete) break;
               n++;
               if (rob[i].halt) begin why = 1; break; end
               if (rob[i].mispredict) begin why = 2; break; end
            end
         end
         for (int i = 0; i < n; i++) begin
            if (rob[i].has_dest && rob[i].arch_dest != 0) efv[i] = 1'b1;
         end
         chk("num_retiring", num_retiring, n);
         chk("free_valid", free_valid, efv);
         for (int i = 0; i < N; i++) begin
            if (efv[i]) chk($sformatf("free_tags[%0d]", i), free_tags[i], rob[i].t_old);
         end
         chk("rollback", rollback, m_flush);
         chk("halted", halted, m_halt);
         for (int a = 0; a < ARCH_REG_SZ; a++) begin
            chk($sformatf("arch_map[%0d]", a), arch_map[a], m_map[a]);
         end
         m_flush = 1'b0;
         for (int i = 0; i < n; i++) begin
            if (efv[i]) m_map[rob[i].arch_dest] = rob[i].t_new;
         end
         if (why == 1) m_halt = 1'b1;
         else if (why == 2) m_flush = 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rob = '0;
      ov  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset arch_map[5]", arch_map[5], 5);
      chk("reset halted", halted, 0);
      chk("reset num_retiring", num_retiring, 0);
      chk("reset rollback", rollback, 0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Idle: nothing valid for three cycles.
      repeat (3) step();
      chk("idle arch_map[5]", arch_map[5], 5);
      chk("idle num_retiring", num_retiring, 0);

      // Oldest two complete, third not.
      rob[0] = mk(1, 1, 3, 10, 20, 0, 0);
      rob[1] = mk(1, 1, 4, 11, 21, 0, 0);
      rob[2] = mk(0, 1, 5, 12, 22, 0, 0);
      ov     = 3;
      #1;
      chk("partial num_retiring", num_retiring, 2);
      chk("partial free_valid", free_valid, 3'b011);
      chk("partial free_tags[0]", free_tags[0], 20);
      chk("partial free_tags[1]", free_tags[1], 21);
      step();
      chk("partial arch_map[3]", arch_map[3], 10);
      chk("partial arch_map[4]", arch_map[4], 11);
      chk("partial arch_map[5]", arch_map[5], 5);

      // Two writers of arch 7: the younger one must win.
      rob[0] = mk(1, 1, 7, 40, 30, 0, 0);
      rob[1] = mk(1, 1, 7, 41, 31, 0, 0);
      rob[2] = mk(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("dup free_valid", free_valid, 3'b011);
      chk("dup free_tags[0]", free_tags[0], 30);
      chk("dup free_tags[1]", free_tags[1], 31);
      step();
      chk("dup arch_map[7]", arch_map[7], 41);

      // Mispredict in entry 1 stops selection before the complete entry 2.
      rob[0] = mk(1, 1, 2, 50, 51, 0, 0);
      rob[1] = mk(1, 1, 9, 52, 53, 0, 1);
      rob[2] = mk(1, 1, 10, 54, 55, 0, 0);
      #1;
      chk("mispred num_retiring", num_retiring, 2);
      step();
      chk("flush rollback", rollback, 1);
      chk("flush num_retiring", num_retiring, 0);
      chk("flush free_valid", free_valid, 0);
      chk("flush arch_map[9]", arch_map[9], 52);
      chk("flush arch_map[10]", arch_map[10], 10);
      step();
      chk("post-flush rollback", rollback, 0);
      chk("post-flush num_retiring", num_retiring, 2);
      ov = 0;

      repeat (1500) begin
         rand_inputs(1'b0);
         step();
      end

      // Reset during the flush cycle.
      ov = 0;
      repeat (2) step();
      rob[0] = mk(1, 1, 12, 60, 61, 0, 1);
      rob[1] = mk(0, 0, 0, 0, 0, 0, 0);
      rob[2] = mk(0, 0, 0, 0, 0, 0, 0);
      ov     = 3;
      step();
      chk("pre-reset rollback", rollback, 1);
      chk("pre-reset arch_map[12]", arch_map[12], 60);
      rst = 1'b1;
      #1;
      chk("mid-flush reset rollback", rollback, 0);
      chk("mid-flush reset arch_map[12]", arch_map[12], 12);
      chk("mid-flush reset arch_map[7]", arch_map[7], 7);
      step();
      rst = 1'b0;
      ov  = 0;
      step();

      // Halt (with mispredict also set) on the oldest entry.
      rob[0] = mk(1, 1, 13, 62, 63, 1, 1);
      rob[1] = mk(1, 1, 14, 1, 2, 0, 0);
      rob[2] = mk(1, 0, 0, 0, 0, 0, 0);
      ov     = 3;
      #1;
      chk("halt num_retiring", num_retiring, 1);
      chk("halt free_valid", free_valid, 3'b001);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("halted flag", halted, 1);
         chk("halted num_retiring", num_retiring, 0);
         chk("halted rollback", rollback, 0);
      end
      chk("halt arch_map[13]", arch_map[13], 62);
      chk("halt arch_map[14]", arch_map[14], 14);

      repeat (6) begin
         rst = 1'b1;
         step();
         rst = 1'b0;
         repeat (300) begin
            rand_inputs(1'b1);
            step();
         end
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
